port_in_debounce: RTL and testbench



---
 rtl/port_in_debounce.sv | 178 +++++++++++++++++
 tb/tb_port_in_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/port_in_debounce.sv
// Synchronises and debounces one raw pad input, publishing a clean level,
// one-cycle rise/fall strobes and saturating toggle/glitch counters.
module port_in_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 10000,
  parameter int   CNT_WIDTH       = 16,
  parameter int   TOGGLE_WIDTH    = 16,
  parameter int   GLITCH_WIDTH    = 8,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_raw,
  input  logic                    en,
  input  logic                    clear_count,
  output logic                    level,
  output logic                    rise,
  output logic                    fall,
  output logic                    pending,
  output logic [TOGGLE_WIDTH-1:0] toggle_count,
  output logic [GLITCH_WIDTH-1:0] glitch_count
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam state_t               RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s;
  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    level_q, level_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    accept, reject;
  logic [TOGGLE_WIDTH-1:0] toggle_q, toggle_d;
  logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser runs regardless of en so s is always current on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (en && s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            accept  = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PEND_HI: begin
        if (!en) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          reject  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (en && !s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            accept  = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PEND_LO: begin
        if (!en) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          reject  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear coincident with an event leaves that counter at 1.
  always_comb begin
    toggle_d = toggle_q;
    glitch_d = glitch_q;
    if (clear_count) begin
      toggle_d = TOGGLE_WIDTH'(accept);
      glitch_d = GLITCH_WIDTH'(reject);
    end else begin
      if (accept && (toggle_q != '1)) toggle_d = toggle_q + TOGGLE_WIDTH'(1);
      if (reject && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= '0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      glitch_q <= glitch_d;
    end
  end

  assign level        = level_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign pending      = (state_q == PEND_HI) || (state_q == PEND_LO);
  assign toggle_count = toggle_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_port_in_debounce.sv
// Directed bench for port_in_debounce: a DEBOUNCE_CYCLES=4 instance for the
// main sequence and a DEBOUNCE_CYCLES=1 instance for the short-path latency.
module tb_port_in_debounce;

  logic clk;
  logic rst_n;
  logic in_raw, en, clear_count;
  logic level, rise, fall, pending;
  logic [3:0] toggle_count;
  logic [7:0] glitch_count;

  logic in_raw_f, en_f, clear_count_f;
  logic level_f, rise_f, fall_f, pending_f;
  logic [3:0] toggle_count_f;
  logic [7:0] glitch_count_f;

  int total = 0;
  int bad   = 0;
  logic saw_rise;

  port_in_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16),
    .TOGGLE_WIDTH(4), .GLITCH_WIDTH(8), .RESET_LEVEL(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .en(en), .clear_count(clear_count),
    .level(level), .rise(rise), .fall(fall), .pending(pending),
    .toggle_count(toggle_count), .glitch_count(glitch_count)
  );

  port_in_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16),
    .TOGGLE_WIDTH(4), .GLITCH_WIDTH(8), .RESET_LEVEL(1'b0)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw_f), .en(en_f), .clear_count(clear_count_f),
    .level(level_f), .rise(rise_f), .fall(fall_f), .pending(pending_f),
    .toggle_count(toggle_count_f), .glitch_count(glitch_count_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean_toggle();
    in_raw = ~in_raw;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; in_raw = 1'b0; en = 1'b1; clear_count = 1'b0;
    in_raw_f = 1'b0; en_f = 1'b1; clear_count_f = 1'b0;
    tick(2);

    // 1. reset state
    check("rst_level",   level, 0);
    check("rst_rise",    rise, 0);
    check("rst_fall",    fall, 0);
    check("rst_pending", pending, 0);
    check("rst_toggle",  toggle_count, 0);
    check("rst_glitch",  glitch_count, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_level", level, 0);

    // 2. clean 0->1: pending at cycles 3..5, level/rise at cycle 6
    in_raw = 1'b1;
    tick(2);
    check("r_pend_c2", pending, 0);
    tick(1);
    check("r_pend_c3", pending, 1);
    tick(2);
    check("r_pend_c5", pending, 1);
    check("r_level_c5", level, 0);
    check("r_rise_c5", rise, 0);
    tick(1);
    check("r_level_c6", level, 1);
    check("r_rise_c6", rise, 1);
    check("r_fall_c6", fall, 0);
    check("r_pend_c6", pending, 0);
    check("r_toggle", toggle_count, 1);
    tick(1);
    check("r_rise_c7", rise, 0);
    check("r_level_c7", level, 1);
    tick(2);

    // 4. clean 1->0: fall at cycle 6 only
    in_raw = 1'b0;
    tick(5);
    check("f_fall_c5", fall, 0);
    check("f_level_c5", level, 1);
    tick(1);
    check("f_fall_c6", fall, 1);
    check("f_rise_c6", rise, 0);
    check("f_level_c6", level, 0);
    check("f_toggle", toggle_count, 2);
    tick(1);
    check("f_fall_c7", fall, 0);
    tick(2);

    // 3. glitch: high for 3 sampling edges, then low
    saw_rise = 1'b0;
    in_raw = 1'b1;
    tick(3);
    in_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      saw_rise |= rise;
    end
    check("g_pend_c5", pending, 1);
    tick(1);
    saw_rise |= rise;
    check("g_pend_c6", pending, 0);
    check("g_glitch", glitch_count, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      saw_rise |= rise;
    end
    check("g_no_rise", saw_rise, 0);
    check("g_level", level, 0);
    check("g_toggle", toggle_count, 2);

    // 5. en dropped mid-qualification, then re-enabled
    in_raw = 1'b1;
    tick(4);
    check("e_pend_before", pending, 1);
    en = 1'b0;
    tick(1);
    check("e_pend_off", pending, 0);
    check("e_rise_off", rise, 0);
    check("e_glitch", glitch_count, 1);
    tick(3);
    check("e_level_off", level, 0);
    check("e_pend_held", pending, 0);
    en = 1'b1;
    tick(3);
    check("e_rise_c3", rise, 0);
    tick(1);
    check("e_rise_c4", rise, 1);
    check("e_level_c4", level, 1);
    check("e_toggle", toggle_count, 3);
    tick(2);

    // 6a. saturation of toggle_count (3 + 12 = 15, then held)
    for (int i = 0; i < 12; i++) clean_toggle();
    check("sat_at_15", toggle_count, 15);
    clean_toggle();
    check("sat_hold", toggle_count, 15);
    check("sat_level", level, 0);

    // 6b. clear coincident with an accepted rise
    in_raw = 1'b1;
    tick(5);
    clear_count = 1'b1;
    tick(1);
    clear_count = 1'b0;
    check("clr_rise", rise, 1);
    check("clr_toggle", toggle_count, 1);
    check("clr_glitch", glitch_count, 0);
    tick(3);

    // 1b. async reset mid-PEND_HI
    in_raw = 1'b0;
    tick(8);
    check("pre_rst_toggle", toggle_count, 2);
    in_raw = 1'b1;
    tick(4);
    check("pre_rst_pend", pending, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pend", pending, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_toggle", toggle_count, 0);
    check("mid_rst_rise", rise, 0);
    in_raw = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 6c. DEBOUNCE_CYCLES=1 build: rise at cycle 3
    in_raw_f = 1'b1;
    tick(2);
    check("fast_rise_c2", rise_f, 0);
    check("fast_pend_c2", pending_f, 0);
    tick(1);
    check("fast_rise_c3", rise_f, 1);
    check("fast_level_c3", level_f, 1);
    check("fast_toggle", toggle_count_f, 1);
    tick(1);
    check("fast_rise_c4", rise_f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
